udma_tx_mux_ot: RTL
===================

Name: udma_tx_mux_ot

Overview:
- Parametrised successor to the uDMA TX read path. Arbitrates N_CH read channels, each supplying its own byte address and size, onto one L2 read port.
- Supports up to MAX_OUTST reads in flight, using credit-based flow control so an L2 response never has to be stalled.
- Extracts the addressed byte, halfword or word from the L2 beat, with optional sign extension, and returns it to the originating channel over a valid/ready handshake.
- Sits between the uDMA channel address generators and the L2 interconnect.

Parameters:
- N_CH, 10, number of read channels (2..32)
- L2_ADDR_WIDTH, 32, L2 word address width
- L2_DATA_WIDTH, 64, L2 beat width (32 or 64 only)
- DATA_WIDTH, 32, channel data width
- MAX_OUTST, 4, maximum reads granted but not yet delivered (power of 2, ≥2)
- AW, L2_ADDR_WIDTH+$clog2(L2_DATA_WIDTH/8), channel byte address width (derived)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- ch_req_i  in  N_CH  per-channel read request
- ch_addr_i  in  N_CH x AW  per-channel byte address
- ch_datasize_i  in  N_CH x 2  size: 0=byte, 1=half, 2=word, 3 is treated as word
- ch_signed_i  in  N_CH  sign-extend the returned data
- ch_gnt_o  out  N_CH  one-hot request accept
- ch_valid_o  out  N_CH  one-hot response valid
- ch_data_o  out  DATA_WIDTH  response data, shared by all channels
- ch_ready_i  in  N_CH  per-channel response ready
- l2_req_o  out  1  L2 read request
- l2_gnt_i  in  1  L2 grant
- l2_addr_o  out  L2_ADDR_WIDTH  L2 word address
- l2_rdata_i  in  L2_DATA_WIDTH  L2 read data
- l2_rvalid_i  in  1  L2 read data valid, never stallable
- outstanding_o  out  $clog2(MAX_OUTST)+1  current credit count
- busy_o  out  1  outstanding_o != 0
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values: every output is 0, including ch_data_o. The arbitration pointer resets to 0. All FIFOs reset to empty.
- Credits:
  - cnt increments on any ch_gnt_o and decrements on a response handshake (ch_valid_o[k] & ch_ready_i[k]).
  - When both occur in the same cycle, cnt is unchanged.
  - cnt never exceeds MAX_OUTST.
- Grant condition: a grant is issued only when all of the following hold:
  - some request is pending;
  - cnt < MAX_OUTST;
  - the request register is empty, or l2_gnt_i & l2_req_o in this cycle.
- Arbitration:
  - Round robin. The highest priority goes to the pointer channel, then increasing index modulo N_CH.
  - After a grant to channel i, the pointer becomes (i+1) mod N_CH.
  - ch_gnt_o is combinational, and at most one bit is set.
- Request register:
  - Loaded on grant with {id, addr, size, signed}.
  - l2_req_o is asserted from the cycle after the grant, i.e. grant at T gives l2_req_o at T+1.
  - l2_req_o, l2_addr_o = addr[AW-1:AW-L2_ADDR_WIDTH] and the register contents are held stable until l2_gnt_i.
- Tag FIFO (depth MAX_OUTST):
  - Pushed with {id, size, byte offset, signed} on l2_req_o & l2_gnt_i.
  - Popped on l2_rvalid_i.
  - It cannot overflow because of the credit limit.
  - A response may arrive, at the earliest, the cycle after the L2 grant.
- Data extraction:
  - The offset is aligned down to the size: byte uses all offset bits, half ignores bit 0, word ignores bits [1:0].
  - Lane = l2_rdata_i[offset*8 +: 8/16/32].
  - The result is zero-extended, or sign-extended from the lane MSB when signed=1.
- Response FIFO (depth MAX_OUTST, registered output):
  - Pushed with {id, data} on l2_rvalid_i.
  - rvalid at R gives ch_valid_o[id] at R+1 at the earliest.
  - The head is presented to channel id only. ch_data_o carries the head data while valid and holds its value otherwise.
  - The head is popped on ch_ready_i[id]. Delivery is in order, and a non-ready head blocks the other channels (accepted, since credits bound the depth).
  - Simultaneous push and pop is allowed, including on a full FIFO.
- Errors:
  - l2_rvalid_i with the tag FIFO empty sets err_o. The data is dropped and cnt is unchanged.
  - err_o is cleared only by reset.
- Channel dropping its request: dropping ch_req_i without a grant is legal and leaves no state behind.
- Reset mid-operation: all in-flight transactions are discarded, and late L2 responses after reset set err_o.

Test Plan:
- Single channel 3, byte read, addr 0x1005, signed=1, L2 beat byte5=0x80 → ch_gnt_o=0x008 at T, l2_req_o at T+1 with l2_addr_o=0x200, ch_valid_o[3] at rvalid+1, ch_data_o=0xFFFFFF80; unsigned case gives 0x00000080.
- Half read at addr 0x3 (offset 3 aligned down to 2), beat bytes[3:2]=0xBEEF → 0x0000BEEF; word read at offset 4 → l2_rdata_i[63:32].
- All 10 channels request continuously with l2_gnt_i=1 → grant order 0,1,...,9,0; no channel is granted twice before all others.
- l2_gnt_i=1 but L2 withholds rvalid; MAX_OUTST=4 → exactly 4 grants, then ch_gnt_o=0 and outstanding_o=4; one delivery frees exactly one grant.
- Channel 2 ch_ready_i=0 while 4 responses for channels 2,5,5,7 arrive on back-to-back cycles → none lost; delivery in order after ch_ready_i[2] rises; outstanding_o returns to 0 and busy_o=0.
- l2_rvalid_i pulsed while idle → err_o=1 and stays 1, no ch_valid_o; rstn_i low clears err_o and outstanding_o.

Source files
------------

// File: rtl/udma_tx_mux_ot.sv
// rtl/udma_tx_mux_ot.sv - multi-outstanding uDMA TX read mux onto one L2 read port
//
// Ports:
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   ch_req_i/ch_addr_i/ch_datasize_i/ch_signed_i
//                                 per-channel read request, byte address, size, sign flag
//   ch_gnt_o                      one-hot request accept (combinational)
//   ch_valid_o/ch_data_o/ch_ready_i
//                                 one-hot response valid, shared data, per-channel ready
//   l2_req_o/l2_gnt_i/l2_addr_o   L2 read request channel (word address)
//   l2_rdata_i/l2_rvalid_i        L2 read response, never stalled
//   outstanding_o/busy_o          credits in use, non-zero credit flag
//   err_o                         sticky unexpected-response flag
module udma_tx_mux_ot #(
  parameter int N_CH          = 10,
  parameter int L2_ADDR_WIDTH = 32,
  parameter int L2_DATA_WIDTH = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_OUTST     = 4,
  parameter int AW            = L2_ADDR_WIDTH + $clog2(L2_DATA_WIDTH/8)
) (
  input  logic                                    clk_i,
  input  logic                                    rstn_i,
  input  logic [N_CH-1:0]                         ch_req_i,
  input  logic [N_CH-1:0][AW-1:0]                 ch_addr_i,
  input  logic [N_CH-1:0][1:0]                    ch_datasize_i,
  input  logic [N_CH-1:0]                         ch_signed_i,
  output logic [N_CH-1:0]                         ch_gnt_o,
  output logic [N_CH-1:0]                         ch_valid_o,
  output logic [DATA_WIDTH-1:0]                   ch_data_o,
  input  logic [N_CH-1:0]                         ch_ready_i,
  output logic                                    l2_req_o,
  input  logic                                    l2_gnt_i,
  output logic [L2_ADDR_WIDTH-1:0]                l2_addr_o,
  input  logic [L2_DATA_WIDTH-1:0]                l2_rdata_i,
  input  logic                                    l2_rvalid_i,
  output logic [$clog2(MAX_OUTST):0]              outstanding_o,
  output logic                                    busy_o,
  output logic                                    err_o
);

  localparam int OFF_W = $clog2(L2_DATA_WIDTH/8);
  localparam int ID_W  = $clog2(N_CH);
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [1:0]       size;
    logic [OFF_W-1:0] off;
    logic             sgn;
  } tag_t;

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  // Arbitration pointer and credit counter
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Request register towards L2
  logic             rreq_valid_q, rreq_valid_d;
  logic [ID_W-1:0]  rreq_id_q, rreq_id_d;
  logic [AW-1:0]    rreq_addr_q, rreq_addr_d;
  logic [1:0]       rreq_size_q, rreq_size_d;
  logic             rreq_sgn_q, rreq_sgn_d;

  // Tag FIFO: one entry per read accepted by L2 and not yet answered
  tag_t             tag_mem_q [MAX_OUTST];
  tag_t             tag_mem_d [MAX_OUTST];
  logic [PTR_W:0]   tag_wr_q, tag_wr_d;
  logic [PTR_W:0]   tag_rd_q, tag_rd_d;

  // Response FIFO: extracted data waiting for channel handshake
  resp_t            resp_mem_q [MAX_OUTST];
  resp_t            resp_mem_d [MAX_OUTST];
  logic [PTR_W:0]   resp_wr_q, resp_wr_d;
  logic [PTR_W:0]   resp_rd_q, resp_rd_d;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  // Combinational helpers
  logic                  arb_found;
  logic [ID_W-1:0]       arb_id;
  logic [AW-1:0]         arb_addr;
  logic [1:0]            arb_size;
  logic                  arb_sgn;
  logic                  grant;
  logic                  tag_empty;
  logic                  tag_push;
  logic                  tag_pop;
  tag_t                  tag_head;
  logic [OFF_W-1:0]      aoff;
  logic [L2_DATA_WIDTH-1:0] lane;
  int                    msb;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  resp_nonempty;
  resp_t                 resp_head;
  logic                  resp_pop;

  // Round robin: first pass covers ptr..N_CH-1, second pass wraps to 0..ptr-1.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    arb_addr  = '0;
    arb_size  = '0;
    arb_sgn   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!arb_found && ch_req_i[i] && (ID_W'(i) >= ptr_q)) begin
        arb_found = 1'b1;
        arb_id    = ID_W'(i);
        arb_addr  = ch_addr_i[i];
        arb_size  = ch_datasize_i[i];
        arb_sgn   = ch_signed_i[i];
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!arb_found && ch_req_i[i]) begin
        arb_found = 1'b1;
        arb_id    = ID_W'(i);
        arb_addr  = ch_addr_i[i];
        arb_size  = ch_datasize_i[i];
        arb_sgn   = ch_signed_i[i];
      end
    end
  end

  // A new grant may reuse the request register in the cycle L2 takes it.
  assign grant = arb_found && (cnt_q < CNT_MAX) && (!rreq_valid_q || l2_gnt_i);

  always_comb begin
    ch_gnt_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch_gnt_o[k] = grant && (arb_id == ID_W'(k));
    end
  end

  assign tag_empty = (tag_wr_q == tag_rd_q);
  assign tag_push  = rreq_valid_q && l2_gnt_i;
  assign tag_pop   = l2_rvalid_i && !tag_empty;
  assign tag_head  = tag_mem_q[tag_rd_q[PTR_W-1:0]];

  // Lane extraction: align the offset down to the access size, then
  // zero- or sign-extend from the lane MSB.
  always_comb begin
    aoff = tag_head.off;
    msb  = 31;
    case (tag_head.size)
      2'd0: msb = 7;
      2'd1: begin
        aoff[0] = 1'b0;
        msb     = 15;
      end
      default: begin
        aoff[1:0] = 2'b00;
        msb       = 31;
      end
    endcase
    lane     = l2_rdata_i >> {aoff, 3'b000};
    ext_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i <= msb) ext_data[i] = lane[i];
      else          ext_data[i] = tag_head.sgn && lane[msb];
    end
  end

  assign resp_nonempty = (resp_wr_q != resp_rd_q);
  assign resp_head     = resp_mem_q[resp_rd_q[PTR_W-1:0]];

  // Only the FIFO head is offered; it goes to its own channel alone.
  always_comb begin
    ch_valid_o = '0;
    resp_pop   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (resp_nonempty && (resp_head.id == ID_W'(k))) begin
        ch_valid_o[k] = 1'b1;
        resp_pop      = ch_ready_i[k];
      end
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    cnt_d        = cnt_q + CNT_W'(grant) - CNT_W'(resp_pop);
    rreq_valid_d = rreq_valid_q;
    rreq_id_d    = rreq_id_q;
    rreq_addr_d  = rreq_addr_q;
    rreq_size_d  = rreq_size_q;
    rreq_sgn_d   = rreq_sgn_q;
    tag_mem_d    = tag_mem_q;
    tag_wr_d     = tag_wr_q;
    tag_rd_d     = tag_rd_q;
    resp_mem_d   = resp_mem_q;
    resp_wr_d    = resp_wr_q;
    resp_rd_d    = resp_rd_q;
    data_d       = resp_nonempty ? resp_head.data : data_q;
    err_d        = err_q || (l2_rvalid_i && tag_empty);

    if (grant) begin
      ptr_d        = (arb_id == ID_W'(N_CH-1)) ? '0 : arb_id + ID_W'(1);
      rreq_valid_d = 1'b1;
      rreq_id_d    = arb_id;
      rreq_addr_d  = arb_addr;
      rreq_size_d  = arb_size;
      rreq_sgn_d   = arb_sgn;
    end else if (l2_gnt_i) begin
      rreq_valid_d = 1'b0;
    end

    if (tag_push) begin
      tag_mem_d[tag_wr_q[PTR_W-1:0]] = '{id:   rreq_id_q,
                                         size: rreq_size_q,
                                         off:  rreq_addr_q[OFF_W-1:0],
                                         sgn:  rreq_sgn_q};
      tag_wr_d = tag_wr_q + 1'b1;
    end

    // Credits bound the total in flight, so the response FIFO has room
    // whenever a tagged response arrives.
    if (tag_pop) begin
      tag_rd_d = tag_rd_q + 1'b1;
      resp_mem_d[resp_wr_q[PTR_W-1:0]] = '{id: tag_head.id, data: ext_data};
      resp_wr_d = resp_wr_q + 1'b1;
    end

    if (resp_pop) begin
      resp_rd_d = resp_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q        <= '0;
      cnt_q        <= '0;
      rreq_valid_q <= 1'b0;
      rreq_id_q    <= '0;
      rreq_addr_q  <= '0;
      rreq_size_q  <= '0;
      rreq_sgn_q   <= 1'b0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      resp_wr_q    <= '0;
      resp_rd_q    <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        tag_mem_q[i]  <= '0;
        resp_mem_q[i] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      rreq_valid_q <= rreq_valid_d;
      rreq_id_q    <= rreq_id_d;
      rreq_addr_q  <= rreq_addr_d;
      rreq_size_q  <= rreq_size_d;
      rreq_sgn_q   <= rreq_sgn_d;
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      resp_wr_q    <= resp_wr_d;
      resp_rd_q    <= resp_rd_d;
      data_q       <= data_d;
      err_q        <= err_d;
      for (int i = 0; i < MAX_OUTST; i++) begin
        tag_mem_q[i]  <= tag_mem_d[i];
        resp_mem_q[i] <= resp_mem_d[i];
      end
    end
  end

  assign ch_data_o     = resp_nonempty ? resp_head.data : data_q;
  assign l2_req_o      = rreq_valid_q;
  assign l2_addr_o     = rreq_addr_q[AW-1:OFF_W];
  assign outstanding_o = cnt_q;
  assign busy_o        = (cnt_q != '0);
  assign err_o         = err_q;

endmodule
